// File: rtl/soc_uart_txfifo_if.sv
// soc_uart_txfifo_if: write-side, status and UART handshake signals of the tx FIFO; UART_TXFIFO_IRQ_EN adds tx_low_irq
interface soc_uart_txfifo_if #(parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          ack;
  logic          tx_enable;
  logic [7:0]    tx_data;
  logic          start_tx;
  logic          tx_empty;
  logic          tx_busy;
`ifdef UART_TXFIFO_IRQ_EN
  logic          tx_low_irq;
`endif
  modport master (
    output wr_en, wr_data, ack, tx_enable, tx_empty,
    input  full, empty, level, overflow, tx_data, start_tx, tx_busy
`ifdef UART_TXFIFO_IRQ_EN
    , input tx_low_irq
`endif
  );
  modport slave (
    input  wr_en, wr_data, ack, tx_enable, tx_empty,
    output full, empty, level, overflow, tx_data, start_tx, tx_busy
`ifdef UART_TXFIFO_IRQ_EN
    , output tx_low_irq
`endif
  );
endinterface

// File: rtl/soc_uart_txfifo.sv
// soc_uart_txfifo: byte FIFO feeding the UART transmitter back-to-back via a held start_tx handshake
// Optional low-water interrupt tx_low_irq enabled by UART_TXFIFO_IRQ_EN
module soc_uart_txfifo #(
  parameter int DEPTH = 16
`ifdef UART_TXFIFO_IRQ_EN
  , parameter int LOW_WATER = 4
`endif
) (
  input  logic uclk,
  input  logic res,
  soc_uart_txfifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level, w_level_nxt;
  logic          r_ovf, r_start;
  logic [7:0]    r_txd;
  logic          w_full, w_empty, w_push, w_pop;
  assign w_full  = r_level == (AW+1)'(DEPTH);
  assign w_empty = r_level == '0;
  assign w_push  = bus.wr_en & ~w_full;
  assign w_pop   = (r_state == IDLE) & ~w_empty & bus.tx_enable & bus.tx_empty;
  // ISSUE persists until the UART drops tx_empty, since it ignores start_tx during its stop bit
  always_comb begin
    w_state_nxt = (r_state == IDLE)  ? (w_pop ? ISSUE : IDLE) :
                  (r_state == ISSUE) ? (bus.tx_empty ? ISSUE : BUSY) :
                                       (bus.tx_empty ? IDLE : BUSY);
    w_level_nxt = (w_push == w_pop) ? r_level :
                  w_push ? r_level + (AW+1)'(1) : r_level - (AW+1)'(1);
  end
  always_ff @(posedge uclk or posedge res)
    if (res) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  always_ff @(posedge uclk or posedge res)
    if (res) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_start  <= 1'b0;
      r_txd    <= 8'h00;
    end else begin
      r_level  <= w_level_nxt;
      r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_ovf    <= (bus.wr_en & w_full) | (r_ovf & ~bus.ack);
      r_start  <= w_state_nxt == ISSUE;
      r_txd    <= w_pop ? r_mem[r_rd_ptr] : r_txd;
    end
  always_ff @(posedge uclk)
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.level    = r_level;
  assign bus.overflow = r_ovf;
  assign bus.tx_data  = r_txd;
  assign bus.start_tx = r_start;
  assign bus.tx_busy  = (r_state != IDLE) | ~w_empty;
`ifdef UART_TXFIFO_IRQ_EN
  localparam logic [AW:0] LW = (AW+1)'(LOW_WATER);
  logic r_arm, r_irq, w_arm_nxt;
  // arming keeps the idle-after-reset FIFO from raising the irq
  assign w_arm_nxt = w_push | (r_arm & ~((w_level_nxt == '0) & (w_state_nxt == IDLE)));
  always_ff @(posedge uclk or posedge res)
    if (res) begin
      r_arm <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_arm <= w_arm_nxt;
      r_irq <= w_arm_nxt & (w_level_nxt <= LW);
    end
  assign bus.tx_low_irq = r_irq;
`endif
endmodule

// File: tb/tb_soc_uart_txfifo.sv
// tb_soc_uart_txfifo: directed stimulus with a byte scoreboard checked by a UART model monitor
module tb_soc_uart_txfifo;
  logic uclk = 1'b0;
  logic res = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int stop_len = 0;
  int busy_len = 3;
  logic [7:0] exp_q [$];

  soc_uart_txfifo_if #(.DEPTH(16)) bus();
  soc_uart_txfifo #(.DEPTH(16)) dut (.uclk(uclk), .res(res), .bus(bus));

  always #5 uclk = ~uclk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit acc);
    @(posedge uclk); #1;
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    if (acc) exp_q.push_back(d);
    @(posedge uclk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_ack();
    @(posedge uclk); #1;
    bus.ack = 1'b1;
    @(posedge uclk); #1;
    bus.ack = 1'b0;
  endtask

  task automatic wait_start();
    int t = 0;
    while (!bus.start_tx && t < 200) begin
      @(posedge uclk); #1;
      t++;
    end
    chk("start_seen", int'(bus.start_tx), 1);
  endtask

  task automatic wait_level(input int lv);
    int t = 0;
    while (int'(bus.level) != lv && t < 500) begin
      @(posedge uclk); #1;
      t++;
    end
    chk("level_reached", int'(bus.level), lv);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || bus.tx_busy || !bus.tx_empty) && t < 3000) begin
      @(posedge uclk); #1;
      t++;
    end
    chk("drained", int'(exp_q.size() == 0 && !bus.tx_busy), 1);
  endtask

  // UART model: waits stop_len cycles before accepting, then stays busy busy_len cycles
  initial begin
    logic [7:0] d0;
    int n;
    forever begin
      @(posedge uclk); #2;
      if (bus.start_tx && !res) begin
        d0 = bus.tx_data;
        n = 0;
        while (n < stop_len && !res) begin
          @(posedge uclk); #2;
          if (!res) begin
            chk("start_held", int'(bus.start_tx), 1);
            chk("data_stable", int'(bus.tx_data), int'(d0));
          end
          n++;
        end
        if (!res) begin
          bus.tx_empty = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_start: got byte %0h expected none", bus.tx_data);
          end else chk("tx_data", int'(bus.tx_data), int'(exp_q.pop_front()));
          repeat (busy_len) begin
            @(posedge uclk); #2;
          end
          bus.tx_empty = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic saw;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.ack = 1'b0;
    bus.tx_enable = 1'b1;
    bus.tx_empty = 1'b1;
    #12;
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_start", int'(bus.start_tx), 0);
    chk("rst_data", int'(bus.tx_data), 0);
    chk("rst_busy", int'(bus.tx_busy), 0);
`ifdef UART_TXFIFO_IRQ_EN
    chk("rst_irq", int'(bus.tx_low_irq), 0);
`endif
    @(posedge uclk); #1;
    res = 1'b0;
    // single byte: latency and handshake
    push(8'h55, 1);
    chk("t1_level1", int'(bus.level), 1);
    chk("t1_nostart", int'(bus.start_tx), 0);
    @(posedge uclk); #1;
    chk("t1_start", int'(bus.start_tx), 1);
    chk("t1_data", int'(bus.tx_data), 8'h55);
    chk("t1_level0", int'(bus.level), 0);
    @(posedge uclk); #1;
    chk("t1_drop", int'(bus.start_tx), 0);
    wait_idle();
    // UART sits in stop bit for 5 cycles before accepting
    stop_len = 5;
    bus.tx_enable = 1'b0;
    push(8'h66, 1);
    push(8'h77, 1);
    bus.tx_enable = 1'b1;
    wait_start();
    repeat (4) begin
      @(posedge uclk); #1;
      chk("t2_one_pop", int'(bus.level), 1);
    end
    wait_idle();
    stop_len = 0;
    // fill, overflow, ordered drain
    bus.tx_enable = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i), 1);
    push(8'hAA, 0);
    chk("t3_full", int'(bus.full), 1);
    chk("t3_ovf", int'(bus.overflow), 1);
    chk("t3_level", int'(bus.level), 16);
    pulse_ack();
    chk("t3_ack_clr", int'(bus.overflow), 0);
    @(posedge uclk); #1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hCC;
    bus.ack = 1'b1;
    @(posedge uclk); #1;
    bus.wr_en = 1'b0;
    bus.ack = 1'b0;
    chk("t3_set_wins", int'(bus.overflow), 1);
    bus.tx_enable = 1'b1;
    wait_idle();
    pulse_ack();
    chk("t3_ovf_clr", int'(bus.overflow), 0);
    // full FIFO with simultaneous push and pop
    bus.tx_enable = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1);
    @(posedge uclk); #1;
    bus.tx_enable = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hBB;
    @(posedge uclk); #1;
    bus.wr_en = 1'b0;
    chk("t4_level", int'(bus.level), 15);
    chk("t4_ovf", int'(bus.overflow), 1);
    chk("t4_start", int'(bus.start_tx), 1);
    wait_idle();
    pulse_ack();
    // reset while ISSUE with 3 bytes queued
    stop_len = 50;
    bus.tx_enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i), 1);
    bus.tx_enable = 1'b1;
    wait_start();
    chk("t5_queued", int'(bus.level), 3);
    @(posedge uclk); #1;
    res = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_start", int'(bus.start_tx), 0);
    chk("t5_level", int'(bus.level), 0);
    chk("t5_empty", int'(bus.empty), 1);
    stop_len = 0;
    @(posedge uclk); #1;
    res = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(posedge uclk); #1;
      saw = saw | bus.start_tx | bus.tx_busy;
    end
    chk("t5_quiet", int'(saw), 0);
    push(8'h99, 1);
    wait_idle();
`ifdef UART_TXFIFO_IRQ_EN
    bus.tx_enable = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i), 1);
    chk("t6_irq_hi_level", int'(bus.tx_low_irq), 0);
    bus.tx_enable = 1'b1;
    wait_level(5);
    chk("t6_irq_at5", int'(bus.tx_low_irq), 0);
    wait_level(4);
    chk("t6_irq_at4", int'(bus.tx_low_irq), 1);
    wait_level(0);
    chk("t6_irq_at0", int'(bus.tx_low_irq), 1);
    wait_idle();
    chk("t6_irq_clr", int'(bus.tx_low_irq), 0);
`endif
    repeat (3) @(posedge uclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/soc_uart_txfifo.md
Name: soc_uart_txfifo

Overview:
- Transmit-side buffer that sits directly upstream of the SoC UART transmitter. It sits between the CPU/bus write path and the UART's tx_data/start_tx/tx_empty interface.
- Queues up to DEPTH bytes and feeds them to the transmitter back-to-back.
- Owns the start_tx handshake, so software never polls tx_empty per byte.
- Runs entirely in the UART clock domain (uclk, 16x baud).

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, 2..256.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.
- LOW_WATER, 4, level threshold for tx_low_irq; only used with UART_TXFIFO_IRQ_EN.

Ports:
- uclk  in  1  clock; all logic on rising edge.
- res  in  1  asynchronous reset, active high.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  8  byte to enqueue.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  AW+1  current byte count, 0..DEPTH.
- overflow  out  1  sticky; a push was attempted while full.
- ack  in  1  clears overflow.
- tx_enable  in  1  when low, no new byte is issued; an in-flight byte completes.
- tx_data  out  8  byte presented to the UART; registered.
- start_tx  out  1  start request to the UART; registered.
- tx_empty  in  1  UART ready indication; high in UART idle and stop-bit states.
- tx_busy  out  1  high while state is not IDLE, or the FIFO is non-empty.
- tx_low_irq  out  1  present only with UART_TXFIFO_IRQ_EN.

Behaviour:
- Reset (async, while res high): rd_ptr = wr_ptr = 0, level = 0, empty = 1, full = 0, overflow = 0, start_tx = 0, tx_data = 8'h00, state = IDLE, tx_low_irq = 0. Memory contents are not reset.
- Reset asserted mid-transfer clears everything immediately. Any queued bytes are lost, and start_tx drops asynchronously.
- Storage: DEPTH x 8 array, AW-bit pointers wrapping modulo DEPTH. level is a separate AW+1-bit counter.
- full = (level == DEPTH); empty = (level == 0).
- Push: wr_en & ~full writes mem[wr_ptr] and increments wr_ptr.
- wr_en & full: data is dropped, overflow is set to 1, and no pointer changes.
- ack clears overflow. If ack and an overflowing push occur in the same cycle, overflow ends at 1 (set wins).
- Pop: occurs only on the IDLE->ISSUE transition.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- A push to a full FIFO in the same cycle as a pop is still rejected; there is no bypass.
- A push into an empty FIFO is poppable no earlier than the following cycle.
- FSM, 3 states:
  - IDLE: if ~empty & tx_enable & tx_empty, then tx_data <= mem[rd_ptr], pop, start_tx <= 1, go to ISSUE.
  - ISSUE: hold start_tx = 1 and tx_data stable until tx_empty is sampled low. Then start_tx <= 0 and go to BUSY.
  - BUSY: wait for tx_empty high, then go to IDLE.
- Why ISSUE holds start_tx: the UART ignores start_tx during its stop-bit state even though tx_empty is high there. So start_tx must persist until acceptance is seen (tx_empty low).
- tx_enable deasserted in ISSUE or BUSY has no effect; the current byte finishes.
- Issue latency: first start_tx high 1 cycle after IDLE sees the conditions.
- Throughput: back-to-back bytes with no extra idle bit time, since the next ISSUE overlaps the UART stop bit.
- tx_busy = (state != IDLE) | ~empty.

Optional Feature:
- Macro: UART_TXFIFO_IRQ_EN.
- Defined: tx_low_irq port exists. It is a registered level signal, high when level <= LOW_WATER and the FIFO was written at least once since reset or since it last went empty.
  - The write condition avoids an irq in the idle-at-reset state.
  - The arm flag sets on any accepted push and clears when the FIFO becomes empty and state returns to IDLE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then push 0x55, tx_empty held high -> next cycle level=1. Following cycle start_tx=1, tx_data=0x55, level=0. start_tx stays high until tx_empty=0, then drops.
- UART model holds tx_empty high for 5 cycles (stop bit) before accepting -> start_tx stays 1 and tx_data stays 0x55 for all 5 cycles. Exactly one byte is popped.
- Push 16 bytes 0x00..0x0F with tx_enable=0, then push 0xAA -> full=1, overflow=1, level=16. Set tx_enable=1 -> bytes leave in order 0x00..0x0F; 0xAA is never sent. ack -> overflow=0.
- Full FIFO, push and pop in the same cycle -> push rejected, overflow=1, level=15.
- Assert res while in ISSUE with 3 bytes queued -> start_tx=0, level=0, empty=1 immediately. After release, no start_tx until a new push.
- With UART_TXFIFO_IRQ_EN, LOW_WATER=4: push 8 bytes and drain -> tx_low_irq rises when level reaches 4. It clears after the last byte and the return to IDLE. It is 0 after reset with no writes.
